// File: rtl/rpn_pkg.sv
// Shared opcode, flag-index and stack-state definitions for the RPN calculator.
package rpn_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_NEG  = 3'b101,
        OP_DUP  = 3'b110,
        OP_SWAP = 3'b111
    } op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU: a is NOS, b is TOS. Produces the result and its NZCV flags.
module rpn_alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    import rpn_pkg::*;

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           c;
    logic           v;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        result = b;
        c      = 1'b0;
        v      = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                result = sum[MSB:0];
                c      = sum[WIDTH];
                v      = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result = diff[MSB:0];
                c      = ~diff[WIDTH];
                v      = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NEG: begin
                result = -b;
                v      = (b == {1'b1, {(WIDTH-1){1'b0}}});
            end
            default: result = b;
        endcase

        flags         = '0;
        flags[FLAG_N] = result[MSB];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end

endmodule

// File: rtl/rpn_stack_calc.sv
// RPN calculator core: DEPTH-entry operand stack, ALU dispatch, one-level undo.
module rpn_stack_calc #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             Enter,
    input  logic             Undo,
    input  logic             IsOp,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] ToDisplay,
    output logic [3:0]       Flags,
    output logic [CW-1:0]    StackCount,
    output logic             Error,
    output logic [1:0]       CurrentState
);
    import rpn_pkg::*;

    localparam int            IW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] stack      [DEPTH];
    logic [WIDTH-1:0] nxt_stack  [DEPTH];
    logic [WIDTH-1:0] hist_stack [DEPTH];
    logic [CW-1:0]    count, nxt_count, hist_count;
    logic [3:0]       flags, nxt_flags, hist_flags;
    logic             hist_valid, error;
    logic             enter_q, undo_q, armed;
    logic             enter_press, undo_press;
    logic             accepted, rejected, is_undo;
    logic             has_one, has_two, not_full;
    logic [IW-1:0]    tos_idx, nos_idx, push_idx;
    logic [WIDTH-1:0] tos, nos, alu_result;
    logic [3:0]       alu_flags;
    op_e              op;
    state_e           cur_state;

    // armed stays low for the first clock after reset so a level held through release is not a press.
    assign enter_press = Enter & ~enter_q & armed;
    assign undo_press  = Undo & ~undo_q & armed;

    assign tos_idx  = IW'(count - CW'(1));
    assign nos_idx  = IW'(count - CW'(2));
    assign push_idx = IW'(count);
    assign tos      = stack[tos_idx];
    assign nos      = stack[nos_idx];
    assign has_one  = (count != '0);
    assign has_two  = (count >= CW'(2));
    assign not_full = (count < FULL_CNT);
    assign op       = op_e'(DataIn[2:0]);

    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (nos),
        .b      (tos),
        .op     (DataIn[2:0]),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_comb begin
        nxt_stack = stack;
        nxt_count = count;
        nxt_flags = flags;
        accepted  = 1'b0;
        rejected  = 1'b0;
        is_undo   = 1'b0;
        if (undo_press) begin
            if (hist_valid) begin
                nxt_stack = hist_stack;
                nxt_count = hist_count;
                nxt_flags = hist_flags;
                accepted  = 1'b1;
                is_undo   = 1'b1;
            end else begin
                rejected = 1'b1;
            end
        end else if (enter_press) begin
            if (!IsOp) begin
                if (not_full) begin
                    nxt_stack[push_idx] = DataIn;
                    nxt_count           = count + CW'(1);
                    accepted            = 1'b1;
                end else begin
                    rejected = 1'b1;
                end
            end else begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        if (has_two) begin
                            nxt_stack[nos_idx] = alu_result;
                            nxt_count          = count - CW'(1);
                            nxt_flags          = alu_flags;
                            accepted           = 1'b1;
                        end else begin
                            rejected = 1'b1;
                        end
                    end
                    OP_NEG: begin
                        if (has_one) begin
                            nxt_stack[tos_idx] = alu_result;
                            nxt_flags          = alu_flags;
                            accepted           = 1'b1;
                        end else begin
                            rejected = 1'b1;
                        end
                    end
                    OP_DUP: begin
                        if (has_one && not_full) begin
                            nxt_stack[push_idx] = tos;
                            nxt_count           = count + CW'(1);
                            accepted            = 1'b1;
                        end else begin
                            rejected = 1'b1;
                        end
                    end
                    OP_SWAP: begin
                        if (has_two) begin
                            nxt_stack[tos_idx] = nos;
                            nxt_stack[nos_idx] = tos;
                            accepted           = 1'b1;
                        end else begin
                            rejected = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // NOTE: the stack and history arrays are reset explicitly, so reset clears any residual undo data.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stack      <= '{default: '0};
            hist_stack <= '{default: '0};
            count      <= '0;
            hist_count <= '0;
            flags      <= '0;
            hist_flags <= '0;
            hist_valid <= 1'b0;
            error      <= 1'b0;
            enter_q    <= 1'b0;
            undo_q     <= 1'b0;
            armed      <= 1'b0;
        end else begin
            enter_q <= Enter;
            undo_q  <= Undo;
            armed   <= 1'b1;
            stack   <= nxt_stack;
            count   <= nxt_count;
            flags   <= nxt_flags;
            if (accepted) begin
                error <= 1'b0;
            end else if (rejected) begin
                error <= 1'b1;
            end
            if (is_undo) begin
                hist_valid <= 1'b0;
            end else if (accepted) begin
                hist_stack <= stack;
                hist_count <= count;
                hist_flags <= flags;
                hist_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        if (count == '0) begin
            cur_state = ST_EMPTY;
        end else if (count == FULL_CNT) begin
            cur_state = ST_FULL;
        end else begin
            cur_state = ST_PARTIAL;
        end
    end

    assign ToDisplay    = has_one ? tos : '0;
    assign Flags        = flags;
    assign StackCount   = count;
    assign Error        = error;
    assign CurrentState = cur_state;

endmodule

// File: doc/rpn_stack_calc.md
Name: rpn_stack_calc

Overview:
Parametrised successor of the fixed two-operand RP calculator core. Holds operands in a DEPTH-entry LIFO stack of WIDTH-bit words and executes arithmetic, logic and stack operators on the top of stack (TOS) and the next entry down (NOS). Supports one-level Undo of any accepted action. Drives the display path (translator) with TOS, and drives the NZCV flag LEDs.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
DEPTH, 4, stack entries (>=2)
CW, $clog2(DEPTH+1), width of StackCount (derived localparam, not overridable)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
Enter  in  1  synchronous level, already debounced; action taken on rising edge
Undo  in  1  synchronous level, already debounced; action taken on rising edge
IsOp  in  1  0: Enter pushes DataIn; 1: Enter executes operator DataIn[2:0]
DataIn  in  WIDTH  operand value, or opcode in [2:0]
ToDisplay  out  WIDTH  TOS; 0 when the stack is empty
Flags  out  4  {N,Z,C,V} of the last ALU result
StackCount  out  CW  number of valid entries, 0..DEPTH
Error  out  1  set by a rejected action, cleared by the next accepted action
CurrentState  out  2  0 EMPTY, 1 PARTIAL, 2 FULL

Behaviour:
- Reset (async, resetN=0): all stack entries 0, StackCount 0, Flags 0, Error 0, history invalid, edge-detect registers 0, CurrentState EMPTY.
- Edge detect: a press is Enter=1 while Enter_q=0 (Enter_q is Enter registered). Undo uses the same scheme. The press is acted on at that clock edge, so outputs change 1 cycle after Enter is first sampled high.
- Enter and Undo presses in the same cycle: Undo executes and Enter is dropped.
- Push (IsOp=0): if StackCount<DEPTH, DataIn becomes the new TOS and the count increments; Flags are unchanged. If the stack is full, the push is rejected.
- Opcodes (IsOp=1), where R is the result:
  - 000 ADD: R=NOS+TOS
  - 001 SUB: R=NOS-TOS
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NEG: R=-TOS (unary)
  - 110 DUP
  - 111 SWAP
- Binary ops (000-100): require count>=2. Pop both, push R; the count decreases by 1.
- NEG: requires count>=1. TOS is replaced by R.
- DUP: requires 1<=count<DEPTH. Pushes a copy of TOS.
- SWAP: requires count>=2. Exchanges TOS and NOS.
- Flags: updated only by ADD, SUB, AND, OR, XOR and NEG.
  - N = R[WIDTH-1]
  - Z = (R==0)
  - ADD: C = carry out; V = signed overflow
  - SUB: C = no-borrow (NOS>=TOS unsigned); V = signed overflow
  - Logic ops: C=0, V=0
  - NEG: C=0; V=1 only when TOS = 1 followed by WIDTH-1 zeros
  - DUP and SWAP leave Flags unchanged.
- Rejected action (overflow, underflow, or Undo with no history): stack, count, Flags and history are unchanged; Error=1.
- Accepted action:
  - Error=0.
  - Before applying the action, the full stack, count and Flags are snapshotted into the history registers, and history is marked valid.
- Undo with valid history: stack, count and Flags are restored from the snapshot; history becomes invalid (one level only); Error=0.
- CurrentState and ToDisplay are combinational from the registered count and stack.
- Stack storage is a register array indexed by count-1. No wrap-around: indices never exceed DEPTH-1.
- Reset mid-operation: an immediate clear with no residual history. A level held high through reset release does not generate a press.

Decomposition:
- rpn_pkg holds:
  - op_e enum (OP_ADD..OP_SWAP, 3 bits)
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - state_e enum (ST_EMPTY, ST_PARTIAL, ST_FULL)
- Sub-module rpn_alu (combinational, parameter WIDTH):
  - inputs: a, b, op
  - outputs: result, flags
- The stack, history and control logic remain in rpn_stack_calc.

Test Plan:
1. WIDTH=16, DEPTH=4: push 0x7FFF, push 0x0001, op ADD -> ToDisplay 0x8000, Flags 4'b1001, StackCount 1, Error 0.
2. Push 0xFFFF, push 0x0001, ADD -> ToDisplay 0x0000, Flags 4'b0110. Then push 0x0003, push 0x0005, SUB -> 0xFFFE, Flags 4'b1000.
3. Push 1, 2, 3, 4 -> CurrentState FULL. Fifth push of 5 -> Error 1, StackCount 4, ToDisplay 4. Then op DUP -> Error stays 1, no change.
4. From empty: op ADD -> Error 1, StackCount 0, ToDisplay 0. Then push 0x8000, NEG -> ToDisplay 0x8000, V=1.
5. Push 0x0010, push 0x0020, ADD (result 0x0030), then Undo -> ToDisplay 0x0020, StackCount 2, prior Flags restored. Second Undo -> Error 1, no change.
6. Enter and Undo rising in the same cycle after one push -> the push is undone, no new push occurs. Assert resetN mid-sequence -> all outputs 0 within the reset cycle.
